// File: rtl/sha1_msg_schedule.sv
// SHA-1 message schedule: loads 16 words, then streams W[0..NUM_ROUNDS-1] over valid/ready.
// Optional block counter output is enabled by defining SHA1_SCHED_BLKCNT_EN.

module rol_32 (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_num,
    output logic [31:0] o_data
);
    logic [63:0] w_dbl;

    // Upper half of the doubled word shifted left is the rotate result.
    assign w_dbl  = {i_data, i_data} << i_num;
    assign o_data = w_dbl[63:32];
endmodule

module sha1_msg_schedule #(
    parameter int NUM_ROUNDS = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [6:0]  w_idx,
`ifdef SHA1_SCHED_BLKCNT_EN
    output logic [31:0] blk_cnt,
`endif
    output logic        w_last
);
    typedef enum logic {S_LOAD, S_EMIT} state_t;

    localparam logic [6:0] LAST_T = 7'(NUM_ROUNDS - 1);

    state_t            r_state;
    logic [3:0]        r_ld_cnt;
    logic [6:0]        r_t;
    logic [15:0][31:0] r_buf;

    logic [31:0] w_xor;
    logic [31:0] w_rol;
    logic [31:0] w_word;
    logic        w_expand;
    logic        w_emit;
    logic        w_is_last;
    logic        w_out_hs;

    assign w_emit    = (r_state == S_EMIT);
    assign w_expand  = (r_t >= 7'd16);
    assign w_is_last = (r_t == LAST_T);
    assign w_out_hs  = w_emit && w_ready && !abort;

    // The slot for t holds W[t-16]; the other taps are offsets modulo 16.
    assign w_xor = r_buf[r_t[3:0] - 4'd3] ^ r_buf[r_t[3:0] - 4'd8]
                 ^ r_buf[r_t[3:0] - 4'd14] ^ r_buf[r_t[3:0]];

    rol_32 u_rol (
        .i_data (w_xor),
        .i_num  (5'd1),
        .o_data (w_rol)
    );

    assign w_word   = w_expand ? w_rol : r_buf[r_t[3:0]];
    assign in_ready = !w_emit;
    assign w_valid  = w_emit;
    assign w_data   = w_emit ? w_word : 32'd0;
    assign w_idx    = w_emit ? r_t : 7'd0;
    assign w_last   = w_emit && w_is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOAD;
            r_ld_cnt <= 4'd0;
            r_t      <= 7'd0;
            r_buf    <= '0;
        end else if (abort) begin
            r_state  <= S_LOAD;
            r_ld_cnt <= 4'd0;
            r_t      <= 7'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_buf[r_ld_cnt] <= in_word;
                        r_ld_cnt        <= r_ld_cnt + 4'd1;
                        if (r_ld_cnt == 4'd15) begin
                            r_state <= S_EMIT;
                            r_t     <= 7'd0;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_ready) begin
                        if (w_expand)
                            r_buf[r_t[3:0]] <= w_rol;
                        if (w_is_last) begin
                            r_state <= S_LOAD;
                            r_t     <= 7'd0;
                        end else begin
                            r_t <= r_t + 7'd1;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

`ifdef SHA1_SCHED_BLKCNT_EN
    logic [31:0] r_blk_cnt;

    // Survives abort; only a completed final handshake counts a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_blk_cnt <= 32'd0;
        else if (w_out_hs && w_is_last)
            r_blk_cnt <= r_blk_cnt + 32'd1;
    end

    assign blk_cnt = r_blk_cnt;
`endif
endmodule
